// File: rtl/ecpri_rma_resp_tx.sv
// eCPRI Remote Memory Access (type 0x04) response framer: latches a request descriptor,
// fetches read data through a 2-entry skid buffer and streams the frame byte-wise.
module ecpri_rma_resp_tx #(
    parameter int         MEM_AW   = 8,
    parameter int         MAX_LEN  = 64,
    parameter int         LEN_W    = 16,
    parameter logic [3:0] REVISION = 4'h1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_read,
    input  logic [7:0]        req_rma_id,
    input  logic [15:0]       req_elem_id,
    input  logic [47:0]       req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              tx_sop,
    output logic              tx_eop,
    input  logic              tx_ready,
    output logic              busy,
    output logic [15:0]       resp_count
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t             state;
    logic               is_read_q, fail_q;
    logic [7:0]         rma_id_q;
    logic [15:0]        elem_id_q;
    logic [47:0]        addr_q;
    logic [LEN_W-1:0]   len_q, data_n_q, data_left, rd_left;
    logic [4:0]         hdr_cnt;
    logic [MEM_AW-1:0]  rd_ptr;
    logic               rd_pend;
    logic [7:0]         sk_q0, sk_q1;
    logic [1:0]         sk_occ, occ_next;

    logic               req_fail, load_ok, load_data, data_avail, pop, push, bypass, rd_window, issue;
    logic [LEN_W-1:0]   req_data_n;
    logic [15:0]        payload, len16;
    logic [7:0]         hdr_byte, data_byte;

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign req_fail   = req_is_read && (req_len > MAX_LEN_L);
    assign req_data_n = (req_is_read && !req_fail) ? req_len : '0;
    assign payload    = 16'(data_n_q) + 16'd12;
    assign len16      = 16'(len_q);

    // An output slot is free when empty or its byte is taken on this edge.
    assign load_ok    = !tx_valid || tx_ready;
    assign data_avail = (sk_occ != 2'd0) || rd_pend;
    assign load_data  = (state == DATA) && load_ok && (data_left != '0) && data_avail;
    assign pop        = load_data && (sk_occ != 2'd0);
    assign bypass     = load_data && (sk_occ == 2'd0);
    assign push       = rd_pend && !bypass;
    assign occ_next   = sk_occ + 2'(push) - 2'(pop);
    assign data_byte  = (sk_occ != 2'd0) ? sk_q0 : mem_rd_data;

    // Reads open once b14 is being loaded; buffered plus outstanding bytes never exceed two.
    assign rd_window = ((state == HDR) && ((hdr_cnt > 5'd14) || ((hdr_cnt == 5'd14) && load_ok)))
                     || (state == DATA);
    assign issue     = rd_window && (rd_left != '0) && (({1'b0, occ_next} + {2'b00, mem_rd_en}) < 3'd2);

    always_comb begin
        // NOTE: default first so every path assigns hdr_byte and no latch is inferred.
        hdr_byte = 8'h00;
        case (hdr_cnt[3:0])
            4'd0:  hdr_byte = {REVISION, 4'h0};
            4'd1:  hdr_byte = 8'h04;
            4'd2:  hdr_byte = payload[15:8];
            4'd3:  hdr_byte = payload[7:0];
            4'd4:  hdr_byte = rma_id_q;
            4'd5:  hdr_byte = {(is_read_q ? 4'h0 : 4'h1), (fail_q ? 4'h2 : 4'h1)};
            4'd6:  hdr_byte = elem_id_q[15:8];
            4'd7:  hdr_byte = elem_id_q[7:0];
            4'd8:  hdr_byte = addr_q[47:40];
            4'd9:  hdr_byte = addr_q[39:32];
            4'd10: hdr_byte = addr_q[31:24];
            4'd11: hdr_byte = addr_q[23:16];
            4'd12: hdr_byte = addr_q[15:8];
            4'd13: hdr_byte = addr_q[7:0];
            4'd14: hdr_byte = len16[15:8];
            default: hdr_byte = len16[7:0];
        endcase
    end

    // NOTE: state lives only in non-blocking assignments; the skid entries are reset as well
    // so a truncated frame leaves nothing stale behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            {is_read_q, fail_q, rma_id_q, elem_id_q, addr_q} <= '0;
            {len_q, data_n_q, data_left, rd_left} <= '0;
            hdr_cnt <= '0;
            rd_ptr <= '0;
            rd_pend <= 1'b0;
            {sk_q0, sk_q1, sk_occ} <= '0;
            mem_rd_en <= 1'b0;
            mem_rd_addr <= '0;
            {tx_data, tx_valid, tx_sop, tx_eop} <= '0;
            resp_count <= '0;
        end else begin
            rd_pend   <= mem_rd_en;
            mem_rd_en <= issue;
            if (issue) begin
                mem_rd_addr <= rd_ptr;
                rd_ptr      <= rd_ptr + MEM_AW'(1);
                rd_left     <= rd_left - LEN_W'(1);
            end

            case ({push, pop})
                2'b10: if (sk_occ == 2'd0) sk_q0 <= mem_rd_data; else sk_q1 <= mem_rd_data;
                2'b01: sk_q0 <= sk_q1;
                2'b11: if (sk_occ == 2'd2) begin
                           sk_q0 <= sk_q1;
                           sk_q1 <= mem_rd_data;
                       end else begin
                           sk_q0 <= mem_rd_data;
                       end
                default: ;
            endcase
            sk_occ <= occ_next;

            case (state)
                IDLE: if (req_valid) begin
                    is_read_q <= req_is_read;
                    fail_q    <= req_fail;
                    rma_id_q  <= req_rma_id;
                    elem_id_q <= req_elem_id;
                    addr_q    <= req_addr;
                    len_q     <= req_fail ? '0 : req_len;
                    data_n_q  <= req_data_n;
                    data_left <= req_data_n;
                    rd_left   <= req_data_n;
                    rd_ptr    <= req_addr[MEM_AW-1:0];
                    tx_data   <= {REVISION, 4'h0};
                    tx_valid  <= 1'b1;
                    tx_sop    <= 1'b1;
                    tx_eop    <= 1'b0;
                    hdr_cnt   <= 5'd1;
                    state     <= HDR;
                end
                HDR: if (load_ok) begin
                    if (!hdr_cnt[4]) begin
                        tx_data  <= hdr_byte;
                        tx_valid <= 1'b1;
                        tx_sop   <= 1'b0;
                        tx_eop   <= (hdr_cnt == 5'd15) && (data_n_q == '0);
                        hdr_cnt  <= hdr_cnt + 5'd1;
                        if ((hdr_cnt == 5'd15) && (data_n_q != '0))
                            state <= DATA;
                    end else begin
                        tx_valid <= 1'b0;
                        tx_eop   <= 1'b0;
                        state    <= DONE;
                    end
                end
                DATA: if (load_ok) begin
                    if (data_left == '0) begin
                        tx_valid <= 1'b0;
                        tx_eop   <= 1'b0;
                        state    <= DONE;
                    end else if (load_data) begin
                        tx_data   <= data_byte;
                        tx_valid  <= 1'b1;
                        tx_eop    <= (data_left == LEN_W'(1));
                        data_left <= data_left - LEN_W'(1);
                    end else begin
                        tx_valid <= 1'b0;
                    end
                end
                default: begin
                    resp_count <= resp_count + 16'd1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
